// File: rtl/soma_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle, LSB slice first.
// Start is accepted only in IDLE; results appear N+1 edges after acceptance and hold until the next completion.
module soma_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_c,
  output logic             o_overflow,
  output logic             o_carry_out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [LW-1:0]    w_lsb;
  logic [DIGIT-1:0] w_a_sl;
  logic [DIGIT-1:0] w_b_sl;
  logic [DIGIT-1:0] w_s_sl;
  logic [DIGIT:0]   w_ext;
  logic             w_cout;
  logic             w_cin_msb;
  logic             w_last;
  logic [WIDTH-1:0] w_result;

  // Slice adder; carry into the slice MSB is recovered from its sum bit.
  always_comb begin
    w_lsb     = LW'(int'(r_cnt) * DIGIT);
    w_a_sl    = r_a[w_lsb +: DIGIT];
    w_b_sl    = r_b[w_lsb +: DIGIT];
    w_ext     = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{DIGIT{1'b0}}, r_carry};
    w_s_sl    = w_ext[DIGIT-1:0];
    w_cout    = w_ext[DIGIT];
    w_cin_msb = w_a_sl[DIGIT-1] ^ w_b_sl[DIGIT-1] ^ w_s_sl[DIGIT-1];
    w_last    = (r_cnt == LAST);
    w_result  = r_sum;
    w_result[w_lsb +: DIGIT] = w_s_sl;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      S_RUN:   o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is folded in at acceptance: B inverted, carry seeded with 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      o_c         <= '0;
      o_overflow  <= 1'b0;
      o_carry_out <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= w_result;
          r_carry <= w_cout;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            o_c         <= w_result;
            o_carry_out <= w_cout;
            o_overflow  <= w_cin_msb ^ w_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soma_serial.sv
// Bench for soma_serial: cycle-count model with whole-word arithmetic, per-cycle compare, directed literals.
module tb_soma_serial;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, ovf, cout;
  logic [W-1:0] c;

  logic         start1 = 1'b0;
  logic         sub1 = 1'b0;
  logic [7:0]   a1 = '0;
  logic [7:0]   b1 = '0;
  logic         busy1, done1, ovf1, cout1;
  logic [7:0]   c1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  soma_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sub(sub), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_c(c), .o_overflow(ovf), .o_carry_out(cout)
  );

  soma_serial #(.WIDTH(8), .DIGIT(8)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_sub(sub1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_done(done1), .o_c(c1), .o_overflow(ovf1), .o_carry_out(cout1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Result from the arithmetic definition: signed range for overflow, unsigned compare for borrow.
  function automatic void calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                               output logic [W-1:0] r, output logic ov, output logic co);
    longint sx, sy, ideal;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ideal = s ? sx - sy : sx + sy;
    ov = (ideal > (2**(W-1)) - 1) || (ideal < -(2**(W-1)));
    r  = s ? x - y : x + y;
    co = s ? (x >= y) : (({1'b0, x} + {1'b0, y}) >> W) != 0;
  endfunction

  int           m_ph = 0;
  logic [W-1:0] m_c = '0, p_c = '0;
  logic         m_ov = 1'b0, m_co = 1'b0, p_ov = 1'b0, p_co = 1'b0;

  // m_ph counts cycles since acceptance: 1..N busy, N+1 done, then idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_c = '0; m_ov = 1'b0; m_co = 1'b0;
    end else if (m_ph == 0) begin
      if (start) begin
        calc(a, b, sub, p_c, p_ov, p_co);
        m_ph = 1;
      end
    end else if (m_ph == N) begin
      m_c = p_c; m_ov = p_ov; m_co = p_co; m_ph = N + 1;
    end else if (m_ph == N + 1) begin
      m_ph = 0;
    end else begin
      m_ph = m_ph + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= N));
      check("cyc_done", 32'(done), 32'(m_ph == N + 1));
      check("cyc_c",    32'(c),    32'(m_c));
      check("cyc_ovf",  32'(ovf),  32'(m_ov));
      check("cyc_cout", 32'(cout), 32'(m_co));
    end
  end

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                    input logic [W-1:0] ec, input logic eo, input logic ecy, input string tag);
    int edges;
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom());
    edges = 1;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_lat"},  32'(edges), 32'(N + 1));
    check({tag, "_c"},    32'(c),     32'(ec));
    check({tag, "_ovf"},  32'(ovf),   32'(eo));
    check({tag, "_cout"}, 32'(cout),  32'(ecy));
    @(posedge clk); #1;
    check({tag, "_hold"}, 32'(c), 32'(ec));
  endtask

  initial begin
    int nd, last_e, e1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_c",    32'(c),    32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0, "add_ovf");
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, "add_wrap");
    op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
    op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

    // Reset during the second RUN cycle aborts the operation.
    a = 16'h0102; b = 16'h0304; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_c",    32'(c),    32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort_nodone", 32'(nd), 32'd0);
    op(16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0, "after_abort");

    // A second request during RUN/DONE is ignored.
    a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF;
    nd = 0;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("ign_done", 32'(nd), 32'd1);
    check("ign_c",    32'(c),  32'h2345);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("ign_extra", 32'(nd), 32'd0);

    // Start held high: one result every N+2 cycles.
    a = 16'h0003; b = 16'h0004; sub = 1'b0; start = 1'b1;
    nd = 0; last_e = 0;
    for (int e = 1; e <= 2 * (N + 2); e++) begin
      @(posedge clk); #1;
      if (done) begin nd++; last_e = e; end
    end
    start = 1'b0;
    check("stream_cnt",  32'(nd),     32'd2);
    check("stream_edge", 32'(last_e), 32'(2 * N + 3));
    check("stream_c",    32'(c),      32'h0007);
    @(posedge clk); #1;

    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
    op(16'h5555, 16'h2AAB, 1'b1, 16'h2AAA, 1'b0, 1'b1, "sub_plain");

    // Single-digit configuration: one RUN cycle.
    a1 = 8'h7F; b1 = 8'h01; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    check("d1_busy", 32'(busy1), 32'd1);
    e1 = 1;
    while (!done1 && e1 < 10) begin
      @(posedge clk); #1;
      e1++;
    end
    check("d1_lat",  32'(e1),    32'd2);
    check("d1_c",    32'(c1),    32'h80);
    check("d1_ovf",  32'(ovf1),  32'd1);
    check("d1_cout", 32'(cout1), 32'd0);
    @(posedge clk); #1;

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
